// File: rtl/ram_responder.sv
// Bridges 32-bit instruction reads and 16-bit halfword writes onto a single 16-bit
// asynchronous SRAM, using a fixed WAIT_CYCLES access time for each halfword.
module ram_responder #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ram_read,
  input  logic        ram_write,
  input  logic [16:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic [31:0] ram_out,
  output logic        ram_data_ready,
  output logic        ram_busy,
  output logic        write_done,
  output logic        req_conflict,
  output logic [16:0] sram_addr,
  output logic [15:0] sram_wdata,
  input  logic [15:0] sram_rdata,
  output logic        sram_oe,
  output logic        sram_we
);

  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, DONE, WR} state_t;

  localparam logic [3:0] RELOAD = 4'(WAIT_CYCLES - 1);

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [16:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] lo_q;
  logic        accepting, take_read, take_write, last_cycle;

  // NOTE: every signal assigned here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    accepting      = (state == IDLE) || (state == DONE);
    take_read      = accepting && ram_read;
    take_write     = accepting && ram_write && !ram_read;
    last_cycle     = (cnt == 4'd0);
    state_nx       = state;
    cnt_nx         = cnt;
    ram_busy       = 1'b0;
    ram_data_ready = 1'b0;
    sram_oe        = 1'b0;
    sram_we        = 1'b0;
    sram_addr      = '0;
    sram_wdata     = '0;

    case (state)
      IDLE, DONE: begin
        ram_data_ready = (state == DONE);
        if (take_read) begin
          state_nx = RD_LO;
          cnt_nx   = RELOAD;
        end else if (take_write) begin
          state_nx = WR;
          cnt_nx   = RELOAD;
        end else begin
          state_nx = IDLE;
        end
      end
      RD_LO: begin
        ram_busy  = 1'b1;
        sram_oe   = 1'b1;
        sram_addr = {addr_q[15:0], 1'b0};
        if (last_cycle) begin
          state_nx = RD_HI;
          cnt_nx   = RELOAD;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      RD_HI: begin
        ram_busy  = 1'b1;
        sram_oe   = 1'b1;
        sram_addr = {addr_q[15:0], 1'b1};
        if (last_cycle) begin
          state_nx = DONE;
          cnt_nx   = RELOAD;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      WR: begin
        ram_busy   = 1'b1;
        sram_we    = 1'b1;
        sram_addr  = addr_q;
        sram_wdata = wdata_q;
        if (last_cycle) begin
          state_nx = IDLE;
          cnt_nx   = RELOAD;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      lo_q         <= '0;
      ram_out      <= '0;
      write_done   <= 1'b0;
      req_conflict <= 1'b0;
    end else begin
      if (take_read) begin
        addr_q <= {1'b0, req_addr[15:0]};
      end else if (take_write) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state == RD_LO && last_cycle) lo_q <= sram_rdata;
      if (state == RD_HI && last_cycle) ram_out <= {sram_rdata, lo_q};
      write_done <= (state == WR) && last_cycle;
      // A write arriving alongside a read is lost; remember that it happened.
      if (accepting && ram_read && ram_write) req_conflict <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// Self-checking bench for ram_responder: SRAM model, transaction-level reference
// model compared every cycle, directed scenarios and randomized traffic.
module tb_ram_responder;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ram_read, ram_write;
  logic [16:0] req_addr;
  logic [15:0] req_wdata;
  logic [31:0] ram_out;
  logic        ram_data_ready, ram_busy, write_done, req_conflict;
  logic [16:0] sram_addr;
  logic [15:0] sram_wdata, sram_rdata;
  logic        sram_oe, sram_we;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  ram_responder #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ram_read(ram_read), .ram_write(ram_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .ram_out(ram_out), .ram_data_ready(ram_data_ready),
    .ram_busy(ram_busy), .write_done(write_done), .req_conflict(req_conflict),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_oe(sram_oe), .sram_we(sram_we)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Power-up contents of the SRAM; two locations are pinned for the directed read.
  function automatic logic [15:0] mem_init(input logic [16:0] a);
    logic [31:0] t;
    if (a == 17'h00020) return 16'hBEEF;
    if (a == 17'h00021) return 16'h1234;
    t = {15'b0, a} * 32'h0000_9E37;
    return t[15:0] ^ 16'h5A5A;
  endfunction

  // External SRAM: asynchronous read, write on posedge while sram_we is high.
  logic [15:0] sram [0:131071];
  assign sram_rdata = sram[sram_addr];
  initial begin
    for (int i = 0; i < 131072; i++) sram[i] = mem_init(17'(i));
    forever begin
      @(posedge clk);
      if (sram_we) sram[sram_addr] <= sram_wdata;
    end
  end

  // Reference model: one outstanding transaction described by its kind and the
  // number of cycles since it was accepted.
  int          op  = 0;   // 0 none, 1 read, 2 write
  int          age = 0;
  logic [15:0] m_raddr = '0;
  logic [16:0] m_waddr = '0;
  logic [15:0] m_wdata = '0;
  logic [31:0] m_out   = '0;
  logic        m_conf  = 1'b0;
  logic [15:0] wr_map [int];

  function automatic logic [15:0] gold(input logic [16:0] a);
    if (wr_map.exists(int'(a))) return wr_map[int'(a)];
    return mem_init(a);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op = 0; age = 0; m_out = '0; m_conf = 1'b0;
    end else begin
      if ((op == 0) || (op == 1 && age == 2*W) || (op == 2 && age == W)) begin
        if (ram_read) begin
          if (ram_write) m_conf = 1'b1;
          op = 1; age = 0; m_raddr = req_addr[15:0];
        end else if (ram_write) begin
          op = 2; age = 0; m_waddr = req_addr; m_wdata = req_wdata;
          wr_map[int'(req_addr)] = req_wdata;
        end else begin
          op = 0;
        end
      end else begin
        age++;
        if (op == 1 && age == 2*W) m_out = {gold({m_raddr, 1'b1}), gold({m_raddr, 1'b0})};
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("busy", 32'(ram_busy), 32'((op == 1 && age < 2*W) || (op == 2 && age < W)));
      check("data_ready", 32'(ram_data_ready), 32'(op == 1 && age == 2*W));
      check("write_done", 32'(write_done), 32'(op == 2 && age == W));
      check("sram_oe", 32'(sram_oe), 32'(op == 1 && age < 2*W));
      check("sram_we", 32'(sram_we), 32'(op == 2 && age < W));
      check("ram_out", ram_out, m_out);
      check("req_conflict", 32'(req_conflict), 32'(m_conf));
      if (op == 1 && age < 2*W)
        check("sram_addr_rd", 32'(sram_addr), 32'({m_raddr, 1'(age >= W)}));
      if (op == 2 && age < W) begin
        check("sram_addr_wr", 32'(sram_addr), 32'(m_waddr));
        check("sram_wdata", 32'(sram_wdata), 32'(m_wdata));
      end
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_ram_out"}, ram_out, 32'h0);
    check({tag, "_ready"}, 32'(ram_data_ready), 32'h0);
    check({tag, "_busy"}, 32'(ram_busy), 32'h0);
    check({tag, "_write_done"}, 32'(write_done), 32'h0);
    check({tag, "_conflict"}, 32'(req_conflict), 32'h0);
    check({tag, "_sram_addr"}, 32'(sram_addr), 32'h0);
    check({tag, "_sram_wdata"}, 32'(sram_wdata), 32'h0);
    check({tag, "_sram_oe"}, 32'(sram_oe), 32'h0);
    check({tag, "_sram_we"}, 32'(sram_we), 32'h0);
  endtask

  task automatic wait_ready(input int limit, output int n, output logic ok);
    n = 0;
    while (!ram_data_ready && n < limit) begin
      @(negedge clk);
      n++;
    end
    ok = ram_data_ready;
  endtask

  int          n, busy_cnt, we_cnt, pulses, t1, r;
  logic        ok;
  logic [15:0] saved;

  initial begin
    ram_read = 1'b0; ram_write = 1'b0; req_addr = '0; req_wdata = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_reset("por");
    @(negedge clk); @(negedge clk);

    // Read word 0x0010 on the very first edge out of reset.
    rst_n = 1'b1; ram_read = 1'b1; req_addr = 17'h00010;
    @(negedge clk); ram_read = 1'b0;
    busy_cnt = 0; n = 0;
    while (!ram_data_ready && n < 20) begin
      if (ram_busy) busy_cnt++;
      n++;
      @(negedge clk);
    end
    check("rd1_busy_cycles", 32'(busy_cnt), 32'd4);
    check("rd1_ready", 32'(ram_data_ready), 32'd1);
    check("rd1_out", ram_out, 32'h1234BEEF);
    check("rd1_not_busy_in_done", 32'(ram_busy), 32'd0);
    t1 = cyc;

    // Back-to-back read raised during DONE, plus a read pulsed while busy.
    ram_read = 1'b1; req_addr = 17'h00011;
    @(negedge clk); ram_read = 1'b0;
    check("rd2_busy", 32'(ram_busy), 32'd1);
    ram_read = 1'b1; req_addr = 17'h00300;
    @(negedge clk); ram_read = 1'b0;
    wait_ready(20, n, ok);
    check("rd2_ready", 32'(ok), 32'd1);
    check("rd2_gap", 32'(cyc - t1), 32'd5);
    check("rd2_out", ram_out, {mem_init(17'h00023), mem_init(17'h00022)});
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (ram_data_ready) pulses++;
    end
    check("dropped_read_no_ready", 32'(pulses), 32'd0);

    // Halfword write, then read the word containing it.
    ram_write = 1'b1; req_addr = 17'h00041; req_wdata = 16'hA5A5;
    @(negedge clk); ram_write = 1'b0;
    we_cnt = 0; n = 0;
    while (!write_done && n < 20) begin
      if (sram_we) we_cnt++;
      n++;
      @(negedge clk);
    end
    check("wr_we_cycles", 32'(we_cnt), 32'd2);
    check("wr_done", 32'(write_done), 32'd1);
    check("wr_sram", 32'(sram[17'h00041]), 32'h0000A5A5);
    ram_read = 1'b1; req_addr = 17'h00020;
    @(negedge clk); ram_read = 1'b0;
    wait_ready(20, n, ok);
    check("wr_rd_ready", 32'(ok), 32'd1);
    check("wr_rd_hi", 32'(ram_out[31:16]), 32'h0000A5A5);

    // Simultaneous read and write: read wins, write lost, flag sticks.
    @(negedge clk);
    saved = sram[17'h00030];
    ram_read = 1'b1; ram_write = 1'b1; req_addr = 17'h00030; req_wdata = ~saved;
    @(negedge clk); ram_read = 1'b0; ram_write = 1'b0;
    wait_ready(20, n, ok);
    check("conf_rd_ready", 32'(ok), 32'd1);
    check("conf_flag", 32'(req_conflict), 32'd1);
    repeat (3) @(negedge clk);
    check("conf_sram_unwritten", 32'(sram[17'h00030]), 32'(saved));
    check("conf_sticky", 32'(req_conflict), 32'd1);

    // Reset during RD_HI.
    ram_read = 1'b1; req_addr = 17'h01234;
    @(negedge clk); ram_read = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rdhi_addr_lsb", 32'(sram_addr[0]), 32'd1);
    #1 rst_n = 1'b0;
    #1 check_reset("rst_mid_read");
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (ram_data_ready) pulses++;
    end
    check("rst_no_ready", 32'(pulses), 32'd0);
    rst_n = 1'b1; ram_read = 1'b1; req_addr = 17'h00010;
    @(negedge clk); ram_read = 1'b0;
    wait_ready(20, n, ok);
    check("post_rst_ready", 32'(ok), 32'd1);
    check("post_rst_latency", 32'(n + 1), 32'd5);
    check("post_rst_out", ram_out, 32'h1234BEEF);

    // Reset during WR; data equals current contents so the location stays defined.
    @(negedge clk);
    ram_write = 1'b1; req_addr = 17'h00100; req_wdata = mem_init(17'h00100);
    @(negedge clk); ram_write = 1'b0;
    check("wr_we_on", 32'(sram_we), 32'd1);
    #1 rst_n = 1'b0;
    #1 check("rst_mid_write_we", 32'(sram_we), 32'd0);
    check_reset("rst_mid_write");
    @(negedge clk); rst_n = 1'b1;

    // Randomized traffic, checked every cycle against the model.
    repeat (400) begin
      @(negedge clk);
      r = int'($urandom_range(0, 99));
      ram_read  = (r < 25) || (r >= 95);
      ram_write = (r >= 25 && r < 40) || (r >= 95);
      req_addr  = 17'($urandom);
      req_wdata = 16'($urandom);
    end
    @(negedge clk);
    ram_read = 1'b0; ram_write = 1'b0;
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_responder.md
RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 SHALL have parameter: WAIT_CYCLES, 1, SRAM cycles per 16-bit access; legal range 1..15.
REQ-002 SHALL have ports (one clock; reset is asynchronous and active-low):
  clk  in  1  sole clock; all state changes on posedge.
  rst_n  in  1  asynchronous active-low reset.
  ram_read  in  1  instruction read request, sampled at posedge.
  ram_write  in  1  halfword write request, sampled at posedge.
  req_addr  in  17  read: [15:0] word address of 32-bit instruction; write: full halfword address.
  req_wdata  in  16  write data.
  ram_out  out  32  instruction word {hi,lo}.
  ram_data_ready  out  1  one-cycle read-complete pulse.
  ram_busy  out  1  request in progress; new requests are dropped.
  write_done  out  1  one-cycle write-complete pulse.
  req_conflict  out  1  sticky: read and write arrived together.
  sram_addr  out  17  external SRAM halfword address.
  sram_wdata  out  16  external SRAM write data.
  sram_rdata  in  16  external SRAM read data.
  sram_oe  out  1  SRAM output enable.
  sram_we  out  1  SRAM write enable.

Function
REQ-003 SHALL implement states IDLE, RD_LO, RD_HI, DONE, WR.
REQ-004 SHALL accept a request at a posedge only in IDLE or DONE ("accepting states"); requests sampled in any other state SHALL be dropped without side effects and are not queued.
REQ-005 SHALL give ram_read priority over ram_write when both are high in an accepting state; the write SHALL be dropped and req_conflict SHALL be set to 1 until reset.
REQ-006 On read accept at edge T0: SHALL latch req_addr[15:0] and enter RD_LO; sram_addr = {addr,1'b0}, sram_oe = 1.
REQ-007 RD_LO SHALL last WAIT_CYCLES cycles; at edge T0+W, SHALL capture sram_rdata into internal lo register and enter RD_HI with sram_addr = {addr,1'b1}, sram_oe = 1.
REQ-008 At edge T0+2W, SHALL load ram_out = {sram_rdata, lo} and enter DONE; ram_out SHALL change at no other edge.
REQ-009 ram_data_ready SHALL be 1 exactly during DONE (one cycle, T0+2W to T0+2W+1); ram_out SHALL hold its value until the next DONE entry.
REQ-010 ram_busy SHALL be 1 exactly in RD_LO, RD_HI and WR; 0 in IDLE and DONE, so a requester's ram_busy check at the accept edge sees 0.
REQ-011 DONE SHALL exit to IDLE, or directly to RD_LO/WR if a request is accepted in it, allowing back-to-back reads every 2W+1 cycles.
REQ-012 On write accept: SHALL latch req_addr and req_wdata and enter WR; sram_we = 1, sram_oe = 0, with address and data stable for all W cycles.
REQ-013 After W WR cycles, SHALL return to IDLE with write_done = 1 for that one IDLE cycle; write SHALL NOT affect ram_out or ram_data_ready.
REQ-014 sram_oe and sram_we SHALL never be 1 simultaneously; both SHALL be 0 in IDLE and DONE.
REQ-015 The wait counter SHALL be 4 bits, reload to W-1 on each state entry, and not wrap.

Reset
REQ-016 rst_n low SHALL immediately, without a clock, force IDLE, ram_out = 0, ram_data_ready = 0, ram_busy = 0, write_done = 0, req_conflict = 0, sram_addr = 0, sram_wdata = 0, sram_oe = 0, sram_we = 0.
REQ-017 Reset mid-read SHALL produce no ram_data_ready; reset mid-write SHALL drop sram_we in the same cycle, leaving SRAM contents undefined at that address.
REQ-018 The first request SHALL be accepted at the first posedge with rst_n high.

Verification (W=2)
REQ-019 Read of addr 0x0010 with SRAM[0x20]=0xBEEF, SRAM[0x21]=0x1234 -> ram_busy 1 for 4 cycles, then ram_data_ready for 1 cycle with ram_out=0x1234BEEF.
REQ-020 Second ram_read raised in the DONE cycle of REQ-019 -> accepted; ram_busy stays 0 only during DONE; second result arrives 5 cycles after first.
REQ-021 ram_read pulsed while ram_busy=1 -> no state change, no extra ram_data_ready; ram_out unchanged.
REQ-022 Write 0xA5A5 to 0x00041, then read word 0x0020 -> sram_we high 2 cycles, write_done pulse, ram_out[31:16]=0xA5A5.
REQ-023 ram_read and ram_write both high in IDLE -> read completes normally, SRAM unwritten, req_conflict=1 until rst_n low.
REQ-024 rst_n low during RD_HI -> all outputs 0 immediately, no ram_data_ready; next read after release completes in 4+1 cycles.
